seg7_scan_mux: RTL
==================

Name: seg7_scan_mux

Overview:
Parametrised N-digit time-multiplexed hex seven-segment driver, the successor to the fixed two-digit display mux in the lab top levels. It takes N packed 4-bit values and scans one shared active-low segment bus across N one-hot digit enables. The scan adds per-slot dead-time for anti-ghosting, a per-digit blank mask, and frame-synchronous shadow latching so a displayed frame never tears. It sits between the lab datapath and the board's segment and digit-driver pins.

Parameters:
NUM_DIGITS, 4, number of digits N (N >= 1)
SLOT_CYCLES, 1000, clk cycles per digit slot (SLOT_CYCLES > DEAD_CYCLES)
DEAD_CYCLES, 8, cycles at the start of each slot with all digits off (>= 0)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
digits  input  4*NUM_DIGITS  hex values; digit i = digits[4i+3:4i]; digit 0 is rightmost
digit_blank  input  NUM_DIGITS  1 = force digit i dark
seg  output  7  segments, active-low; seg[6]=g ... seg[0]=a
dig_en  output  NUM_DIGITS  one-hot digit enable, active-high
frame_start  output  1  one-cycle pulse at the start of each scan frame

Behaviour:
- Reset asserted (reset=0), asynchronously and at any time, including mid-frame:
  - seg=7'h7F, dig_en=0, frame_start=0.
  - Slot counter, digit index and shadow registers (digits and blank) are cleared to 0.
- Timeline: edge 0 is the first rising clk edge with reset=1.
  - For edge t >= 0: p = t mod (N*SLOT_CYCLES), idx = p / SLOT_CYCLES, k = p mod SLOT_CYCLES.
  - After edge t, outputs are a function of (idx, k) as defined below. All outputs are registered; there are no combinational paths from inputs to outputs.
- Shadow latch:
  - On each edge where p==0, digits and digit_blank are sampled into the shadow registers.
  - frame_start=1 after every edge where p==0, otherwise 0.
  - Input changes at any other time have no effect until the next frame.
- Dead phase (k < DEAD_CYCLES): dig_en=0, seg=7'h7F.
- Lit phase (k >= DEAD_CYCLES):
  - If shadow_blank[idx]=1: dig_en=0, seg=7'h7F for the whole slot.
  - Otherwise: dig_en = 1<<idx, seg = decode(shadow[idx]).
- dig_en is never more than one-hot. Between slots there is always a gap of at least DEAD_CYCLES with all digits off; there is none when DEAD_CYCLES=0.
- Scan order is idx 0,1,...,N-1, wrapping back to 0. The wrap starts a new frame.
- Decode table (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- NUM_DIGITS=1: idx is always 0; a frame equals one slot.
- Counter widths are $clog2 of their ranges. The counters must not overflow for any legal parameters.

Optional Feature:
Macro: SEG7_LEADING_ZERO_BLANK_EN
- Defined: digits from idx N-1 downward whose shadow value is 0 are treated as blanked, up to the first nonzero digit.
  - Digit 0 is never blanked by this rule.
  - The result is ORed with shadow_blank.
  - The decision is computed from shadow values only, so it is stable for the whole frame.
- Undefined: zero digits display "0" (1000000) unless digit_blank is set.

Test Plan:
Bench parameters: NUM_DIGITS=2, SLOT_CYCLES=20, DEAD_CYCLES=4.
1. Hold reset=0 for 3 cycles with digits=8'h23 -> seg=7'h7F, dig_en=0, frame_start=0. Release reset -> after edge 0 frame_start=1, dig_en=0. Edges 4..19: dig_en=01, seg=0110000. Edges 20..23: dig_en=00. Edges 24..39: dig_en=10, seg=0100100. Edge 40: frame_start=1.
2. digits=8'hFE -> digit 0 slot seg=0000110; digit 1 slot seg=0001110.
3. Tearing: digits=8'h23, change to 8'h88 after edge 25 -> digit 1 still shows 0100100 through edge 39. From edge 44 digit 0 shows 0000000; edges 64..79 digit 1 shows 0000000.
4. digit_blank=2'b10, digits=8'h47 -> digit 0 lit 1111000; digit 1 slot dig_en=00, seg=7'h7F for all 20 cycles.
5. Reset low for 1 cycle mid-slot at edge 30 -> outputs go dark immediately, without waiting for a clock edge. After release, the timeline restarts at a new edge 0 with frame_start=1.
6. digits=8'h05, blank=0:
   - With SEG7_LEADING_ZERO_BLANK_EN: digit 1 dark, digit 0 shows 0010010.
   - Without the macro: digit 1 shows 1000000.
   - With the macro and digits=8'h00: digit 0 shows 1000000.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: N-digit time-multiplexed hex seven-segment driver.
// One shared active-low segment bus is scanned across one-hot digit
// enables. Each slot opens with a dead phase where every digit is off,
// and the digit values and blank mask are latched once per frame so a
// displayed frame never mixes old and new values.
//
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN
//   When defined, zero digits counted down from the most significant one
//   are dark up to the first nonzero digit. Digit 0 always stays lit.
//
// The position registers hold the slot position that the *next* clock
// edge represents, so the first edge after reset is frame position 0.

module seg7_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 1000,
  parameter int DEAD_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_start
);

  localparam int KW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [KW-1:0] K_LAST   = KW'(SLOT_CYCLES - 1);
  localparam logic [KW-1:0] K_ONE    = KW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [KW-1:0]           pos_k;
  logic [IW-1:0]           pos_idx;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_blank;

  logic                    frame_edge;
  logic [4*NUM_DIGITS-1:0] cur_digits;
  logic [NUM_DIGITS-1:0]   cur_blank;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_val;
  logic                    cur_dark;
  logic                    dead_phase;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   en_nxt;

  // The edge at frame position 0 is the one that latches new inputs.
  always_comb frame_edge = (pos_idx == '0) && (pos_k == '0);

  // On the latching edge the freshly sampled inputs drive the outputs directly,
  // so a zero dead phase still shows the new frame's first digit correctly.
  always_comb begin
    cur_digits = frame_edge ? digits      : shadow_digits;
    cur_blank  = frame_edge ? digit_blank : shadow_blank;
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic lz_run;

  // Walk down from the top digit; stay dark while every digit so far is zero.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run      = lz_run & (cur_digits[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_run;
    end
  end
`else
  // Leading-zero suppression is not built; only the explicit mask blanks.
  always_comb lz_blank = '0;
`endif

  // Select the active digit and decide what the bus shows after this edge.
  always_comb begin
    cur_val  = 4'h0;
    cur_dark = 1'b1;
    en_nxt   = '0;
    seg_nxt  = SEG_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (pos_idx == IW'(i)) begin
        cur_val   = cur_digits[4*i +: 4];
        cur_dark  = cur_blank[i] | lz_blank[i];
        en_nxt[i] = 1'b1;
      end
    end
    dead_phase = int'(pos_k) < DEAD_CYCLES;
    if (dead_phase || cur_dark) begin
      en_nxt  = '0;
      seg_nxt = SEG_OFF;
    end else begin
      seg_nxt = hex_to_seg(cur_val);
    end
  end

  // Slot and digit counters; the digit index wraps to start a new frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_k   <= '0;
      pos_idx <= '0;
    end else if (pos_k == K_LAST) begin
      pos_k   <= '0;
      pos_idx <= (pos_idx == IDX_LAST) ? '0 : pos_idx + IDX_ONE;
    end else begin
      pos_k <= pos_k + K_ONE;
    end
  end

  // Shadow copies of the inputs, refreshed only at the start of a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_digits <= '0;
      shadow_blank  <= '0;
    end else if (frame_edge) begin
      shadow_digits <= digits;
      shadow_blank  <= digit_blank;
    end
  end

  // Registered pin drivers; reset forces the display dark immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg         <= SEG_OFF;
      dig_en      <= '0;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_nxt;
      dig_en      <= en_nxt;
      frame_start <= frame_edge;
    end
  end

endmodule
